// File: rtl/msrv32_wb_arbiter.sv
// msrv32_wb_arbiter: round-robin write-back arbiter with register scoreboard and RAW stall
module msrv32_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_n_in,
  input  logic [2:0]            req_valid_in,
  input  logic [3*ADDR_W-1:0]   req_rd_addr_in,
  input  logic [3*DATA_W-1:0]   req_data_in,
  output logic [2:0]            req_ready_out,
  output logic                  wr_en_out,
  output logic [ADDR_W-1:0]     rd_addr_out,
  output logic [DATA_W-1:0]     rd_out,
  input  logic                  iss_valid_in,
  input  logic [ADDR_W-1:0]     iss_rd_addr_in,
  input  logic [ADDR_W-1:0]     rs_1_addr_in,
  input  logic [ADDR_W-1:0]     rs_2_addr_in,
  input  logic                  rs_1_used_in,
  input  logic                  rs_2_used_in,
  output logic [31:0]           pending_out,
  output logic                  stall_out
);
  logic [1:0]        ptr_q, ptr_d;
  logic [2:0]        gnt;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, sel_addr;
  logic [DATA_W-1:0] rd_q, rd_d, sel_data;
  logic [31:0]       pending_q, pending_d;
  logic              hz_1, hz_2;
  // first valid requester scanning from ptr, wrapping mod 3
  always_comb begin
    gnt = (ptr_q == 2'd0) ? (req_valid_in[0] ? 3'b001 : req_valid_in[1] ? 3'b010 : req_valid_in[2] ? 3'b100 : 3'b000) :
          (ptr_q == 2'd1) ? (req_valid_in[1] ? 3'b010 : req_valid_in[2] ? 3'b100 : req_valid_in[0] ? 3'b001 : 3'b000) :
                            (req_valid_in[2] ? 3'b100 : req_valid_in[0] ? 3'b001 : req_valid_in[1] ? 3'b010 : 3'b000);
  end
  assign req_ready_out = gnt;
  assign sel_addr = gnt[1] ? req_rd_addr_in[ADDR_W +: ADDR_W] : gnt[2] ? req_rd_addr_in[2*ADDR_W +: ADDR_W] : req_rd_addr_in[0 +: ADDR_W];
  assign sel_data = gnt[1] ? req_data_in[DATA_W +: DATA_W] : gnt[2] ? req_data_in[2*DATA_W +: DATA_W] : req_data_in[0 +: DATA_W];
  // next pointer, output stage and scoreboard; an issue to the same register beats a retiring write
  always_comb begin
    ptr_d     = gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : gnt[2] ? 2'd0 : ptr_q;
    wr_en_d   = (|gnt) && (sel_addr != '0);
    rd_addr_d = (|gnt) ? sel_addr : rd_addr_q;
    rd_d      = (|gnt) ? sel_data : rd_q;
    pending_d = pending_q;
    if (wr_en_q) pending_d[rd_addr_q] = 1'b0;
    if (iss_valid_in && iss_rd_addr_in != '0) pending_d[iss_rd_addr_in] = 1'b1;
    pending_d[0] = 1'b0;
  end
  // state registers; reset drops any in-flight write
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      ptr_q     <= 2'd0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_q      <= '0;
      pending_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
      pending_q <= pending_d;
    end
  end
  assign hz_1 = rs_1_used_in && rs_1_addr_in != '0 && pending_q[rs_1_addr_in] && !(wr_en_q && rd_addr_q == rs_1_addr_in);
  assign hz_2 = rs_2_used_in && rs_2_addr_in != '0 && pending_q[rs_2_addr_in] && !(wr_en_q && rd_addr_q == rs_2_addr_in);
  assign stall_out   = hz_1 | hz_2;
  assign wr_en_out   = wr_en_q;
  assign rd_addr_out = rd_addr_q;
  assign rd_out      = rd_q;
  assign pending_out = pending_q;
endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// tb_msrv32_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_msrv32_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  valid;
  logic [14:0] raddr;
  logic [95:0] rdata;
  logic [2:0]  ready;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_out;
  logic        iss_v;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        u1, u2;
  logic [31:0] pending;
  logic        stall;
  int errors = 0;
  int checks = 0;
  int          m_ptr;
  logic        m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_pend;

  msrv32_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .req_valid_in(valid), .req_rd_addr_in(raddr), .req_data_in(rdata),
    .req_ready_out(ready), .wr_en_out(wr_en), .rd_addr_out(rd_addr), .rd_out(rd_out),
    .iss_valid_in(iss_v), .iss_rd_addr_in(iss_rd),
    .rs_1_addr_in(rs1), .rs_2_addr_in(rs2), .rs_1_used_in(u1), .rs_2_used_in(u2),
    .pending_out(pending), .stall_out(stall));

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_grant(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++)
      if (v[(p + k) % 3]) return 3'(1 << ((p + k) % 3));
    return 3'b000;
  endfunction

  function automatic logic src_hazard(input logic used, input logic [4:0] s);
    return used && s != 0 && m_pend[s] && !(m_wr && m_addr == s);
  endfunction

  // reference model: what the register file port and scoreboard should show after each edge
  always @(posedge clk or negedge rst_n) begin
    logic [2:0]  g;
    logic [31:0] np;
    if (!rst_n) begin
      m_ptr <= 0; m_wr <= 1'b0; m_addr <= '0; m_data <= '0; m_pend <= '0;
    end else begin
      g  = exp_grant(valid, m_ptr);
      np = m_pend;
      if (m_wr) np[m_addr] = 1'b0;
      if (iss_v && iss_rd != 0) np[iss_rd] = 1'b1;
      m_pend <= np;
      m_wr   <= 1'b0;
      for (int i = 0; i < 3; i++)
        if (g[i]) begin
          m_ptr  <= (i + 1) % 3;
          m_wr   <= raddr[i*5 +: 5] != 0;
          m_addr <= raddr[i*5 +: 5];
          m_data <= rdata[i*32 +: 32];
        end
    end
  end

  task automatic idle();
    valid = 3'b000; iss_v = 1'b0; u1 = 1'b0; u2 = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    valid[i] = 1'b1; raddr[i*5 +: 5] = a; rdata[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle(); raddr = '0; rdata = '0; iss_rd = '0; rs1 = '0; rs2 = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || rd_addr !== 5'd0 || rd_out !== 32'd0) begin errors++; $display("FAIL reset_out: wr_en=%b addr=%0d data=%h want 0/0/0", wr_en, rd_addr, rd_out); end
    checks++; if (pending !== 32'd0 || ready !== 3'b000) begin errors++; $display("FAIL reset_state: pending=%h ready=%b want 0/000", pending, ready); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 5'd4, 32'h44); iss_v = 1'b1; iss_rd = 5'd4;
    @(posedge clk) #1;
    checks++; if (wr_en !== 1'b1 || pending !== 32'h10) begin errors++; $display("FAIL reset_pre: wr_en=%b pending=%h want 1/00000010", wr_en, pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || pending !== 32'd0 || rd_addr !== 5'd0) begin errors++; $display("FAIL reset_async: wr_en=%b pending=%h addr=%0d want 0/0/0", wr_en, pending, rd_addr); end
    @(negedge clk);
    idle(); rst_n = 1'b1;
    set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2);
    #1;
    checks++; if (ready !== 3'b001) begin errors++; $display("FAIL reset_first_grant: ready=%b want 001", ready); end
    @(posedge clk);
  endtask

  task automatic test_round_robin();
    logic [2:0]  eg [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [4:0]  ea [4] = '{5'd5, 5'd6, 5'd7, 5'd8};
    logic [31:0] ed [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_reset();
    @(negedge clk);
    set_req(0, 5'd5, 32'hA); set_req(1, 5'd6, 32'hB); set_req(2, 5'd7, 32'hC);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (ready !== eg[k]) begin errors++; $display("FAIL rr_grant%0d: ready=%b want %b", k, ready, eg[k]); end
      @(posedge clk) #1;
      checks++; if (wr_en !== 1'b1 || rd_addr !== ea[k] || rd_out !== ed[k]) begin errors++; $display("FAIL rr_write%0d: wr_en=%b x%0d=%h want 1 x%0d=%h", k, wr_en, rd_addr, rd_out, ea[k], ed[k]); end
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (eg[k][i]) set_req(i, 5'(8 + k), 32'hD + k);
    end
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    set_req(1, 5'd0, 32'hDEADBEEF);
    #1;
    checks++; if (ready !== 3'b010) begin errors++; $display("FAIL x0_ready: ready=%b want 010", ready); end
    @(posedge clk) #1;
    checks++; if (wr_en !== 1'b0 || pending !== 32'd0) begin errors++; $display("FAIL x0_write: wr_en=%b pending=%h want 0/0", wr_en, pending); end
    @(negedge clk) idle();
    @(posedge clk) #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL x0_after: wr_en=%b want 0", wr_en); end
  endtask

  task automatic test_hazard();
    do_reset();
    @(negedge clk);
    iss_v = 1'b1; iss_rd = 5'd3;
    @(posedge clk) #1;
    checks++; if (pending !== 32'h8) begin errors++; $display("FAIL hz_set: pending=%h want 00000008", pending); end
    @(negedge clk);
    iss_v = 1'b0; rs1 = 5'd3; u1 = 1'b1; rs2 = 5'd3; u2 = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_rs1: stall=%b want 1", stall); end
    u1 = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hz_rs2_unused: stall=%b want 0", stall); end
    u2 = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_rs2: stall=%b want 1", stall); end
    u2 = 1'b0; u1 = 1'b1;
    set_req(0, 5'd3, 32'h33);
    @(posedge clk) #1;
    checks++; if (wr_en !== 1'b1 || rd_addr !== 5'd3 || pending[3] !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL hz_bypass: wr_en=%b addr=%0d p3=%b stall=%b want 1/3/1/0", wr_en, rd_addr, pending[3], stall); end
    @(negedge clk) valid = 3'b000;
    @(posedge clk) #1;
    checks++; if (pending !== 32'd0 || stall !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL hz_clear: pending=%h stall=%b wr_en=%b want 0/0/0", pending, stall, wr_en); end
    @(negedge clk) idle();
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk);
    iss_v = 1'b1; iss_rd = 5'd9; set_req(0, 5'd9, 32'h99);
    @(posedge clk) #1;
    checks++; if (wr_en !== 1'b1 || rd_addr !== 5'd9 || pending !== 32'h200) begin errors++; $display("FAIL col_pre: wr_en=%b addr=%0d pending=%h want 1/9/00000200", wr_en, rd_addr, pending); end
    @(negedge clk) valid = 3'b000;
    @(posedge clk) #1;
    checks++; if (pending !== 32'h200 || wr_en !== 1'b0) begin errors++; $display("FAIL col_setwins: pending=%h wr_en=%b want 00000200/0", pending, wr_en); end
    @(negedge clk) idle();
    @(posedge clk) #1;
    checks++; if (pending !== 32'h200) begin errors++; $display("FAIL col_hold: pending=%h want 00000200", pending); end
  endtask

  task automatic test_ptr_hold();
    do_reset();
    @(negedge clk);
    set_req(2, 5'd1, 32'h1);
    #1;
    checks++; if (ready !== 3'b100) begin errors++; $display("FAIL ph_csr: ready=%b want 100", ready); end
    @(negedge clk) idle();
    @(negedge clk);
    @(negedge clk);
    set_req(0, 5'd2, 32'h2); set_req(1, 5'd3, 32'h3);
    #1;
    checks++; if (ready !== 3'b001) begin errors++; $display("FAIL ph_alu_first: ready=%b want 001", ready); end
    @(posedge clk);
    @(negedge clk) idle();
  endtask

  task automatic test_random();
    logic [2:0] acc = 3'b111;
    logic [2:0] eg;
    logic       es;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (!valid[i] || acc[i]) begin
          valid[i] = ($urandom_range(0, 2) != 0);
          raddr[i*5 +: 5] = 5'($urandom_range(0, 7));
          rdata[i*32 +: 32] = $urandom;
        end
      iss_v = 1'($urandom); iss_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      u1 = 1'($urandom); u2 = 1'($urandom);
      #1;
      eg = exp_grant(valid, m_ptr);
      es = src_hazard(u1, rs1) || src_hazard(u2, rs2);
      acc = eg;
      checks++; if (ready !== eg || stall !== es) begin errors++; $display("FAIL rnd_comb%0d: ready=%b stall=%b want %b/%b", c, ready, stall, eg, es); end
      @(posedge clk) #1;
      checks++; if (wr_en !== m_wr || rd_addr !== m_addr || rd_out !== m_data || pending !== m_pend) begin errors++; $display("FAIL rnd_out%0d: wr_en=%b x%0d=%h pend=%h want %b x%0d=%h pend=%h", c, wr_en, rd_addr, rd_out, pending, m_wr, m_addr, m_data, m_pend); end
    end
    @(negedge clk) idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_x0();
    test_hazard();
    test_collision();
    test_ptr_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/msrv32_wb_arbiter.md
# msrv32_wb_arbiter

Write-back arbiter and register scoreboard for the msrv32 integer register file. Three result producers (ALU, load/store unit, CSR unit) compete for the register file's single write port. The block grants them round-robin and presents one registered write per cycle. It also tracks destination registers with outstanding writes so decode can stall on read-after-write hazards. It sits between the execute/memory stages and the register file write port, beside decode.

## Interface
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.
- `ms_riscv32_mp_clk_in` in 1: clock; all state updates on the rising edge.
- `ms_riscv32_mp_rst_n_in` in 1: reset, asynchronous, active-low.
- `req_valid_in` in 3: per-requester write request; bit 0 ALU, bit 1 LSU, bit 2 CSR.
- `req_rd_addr_in` in 3*ADDR_W: destination address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data_in` in 3*DATA_W: write data; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready_out` out 3: one-hot grant; a request is accepted on an edge where valid and ready are both 1.
- `wr_en_out` out 1: write enable to the register file.
- `rd_addr_out` out ADDR_W: write address to the register file.
- `rd_out` out DATA_W: write data to the register file.
- `iss_valid_in` in 1: decode issues an instruction that will write rd.
- `iss_rd_addr_in` in ADDR_W: destination of the issued instruction.
- `rs_1_addr_in`, `rs_2_addr_in` in ADDR_W: source addresses of the instruction in decode.
- `rs_1_used_in`, `rs_2_used_in` in 1: the instruction reads that source.
- `pending_out` out 32: scoreboard; bit n = 1 means a write to xn is outstanding.
- `stall_out` out 1: decode must hold.

## Operation
- **Arbitration (combinational)**
  - `ptr` (2-bit, values 0..2) names the highest-priority requester.
  - Grant the first valid requester scanning ptr, ptr+1, ptr+2 (mod 3).
  - `req_ready_out` is the one-hot grant; it is 0 when no request is valid.
  - Ready never asserts for a requester whose valid is 0.
- **Pointer update**: on an accepted grant to requester i, `ptr` becomes (i+1) mod 3. With no grant, `ptr` holds.
- **Output stage**: a registered single entry that drains every cycle, so it never back-pressures.
  - On an edge with a grant: `wr_en_out` = 1 when the granted rd != 0, else 0; `rd_addr_out` and `rd_out` load the granted fields.
  - With no grant: `wr_en_out` = 0; address and data hold.
- **Writes to x0**: accepted (ready = 1) and consumed, but never drive `wr_en_out`.
- **Scoreboard**, updated per edge:
  - Set bit a when `iss_valid_in` is 1 and a = `iss_rd_addr_in` != 0.
  - Clear bit `rd_addr_out` when `wr_en_out` is 1.
  - If a set and a clear hit the same bit on the same edge, the set wins.
  - Bit 0 is always 0.
- **Stall (combinational)**: `stall_out` = 1 if, for either source s (s = rs_1 or rs_2), all of the following hold:
  - `rs_s_used_in` is 1;
  - the source address != 0;
  - its `pending_out` bit is 1;
  - NOT (`wr_en_out` = 1 AND `rd_addr_out` equals the source address). The register file bypass supplies that value in this cycle.
- **Requester obligations**: each requester holds valid, address and data stable until accepted. The arbiter does not check this.

## Timing
- **Reset values** (asynchronous; apply immediately on reset assertion, including mid-operation): `wr_en_out` = 0, `rd_addr_out` = 0, `rd_out` = 0, `ptr` = 0, `pending_out` = 0.
  - Combinational outputs follow from these values.
  - An in-flight registered write is dropped.
- **Latency**: request accepted at edge N gives `wr_en_out` high for exactly cycle N..N+1; the register file commits at edge N+1.
- **Throughput**: one write per cycle. With all three requesters continuously valid, grants rotate 0,1,2,0,…
- **Ready**: combinational from `req_valid_in` and `ptr`; no same-cycle dependency on `wr_en_out`.
- **Scoreboard timing**: a bit set at edge N is visible in `pending_out` during cycle N+1. A bit cleared at edge N+1 (write cycle) is visible as 0 from N+1.

## Test plan
- **Reset**: assert reset mid-write with `wr_en_out` = 1 and `pending_out` = 0x0000_0010 → `wr_en_out` = 0 and `pending_out` = 0 immediately, before the next edge; after release, first grant goes to ALU.
- **Round-robin**: all three valid with rd = 5, 6, 7 and data 0xA, 0xB, 0xC, held after acceptance with new values → grants 001, 010, 100, 001. Register-file writes x5=0xA, x6=0xB, x7=0xC on consecutive cycles, each one cycle after acceptance.
- **x0 write**: LSU alone, rd = 0, data 0xDEADBEEF → `req_ready_out` = 010, `wr_en_out` stays 0, `pending_out` unchanged.
- **Hazard**:
  - Issue rd = 3; next cycle rs_1 = 3 used → `stall_out` = 1.
  - ALU writes x3 → `stall_out` = 0 in the `wr_en_out` cycle (bypass), and bit 3 = 0 afterwards.
  - The rs_2 = 3 case with used = 0 never stalls.
- **Set/clear collision**: `wr_en_out` = 1 for x9 while `iss_valid_in` issues rd = 9 → bit 9 remains 1 after the edge.
- **Pointer hold**: grant to CSR, then two idle cycles, then ALU and LSU valid → ALU granted first (ptr = 0 retained).
